// File: rtl/axi_coalesce_pkg.sv
// Shared state encoding, fixed AXI field values and line geometry for the
// narrow-to-wide AXI write coalescer (optional idle flush: AXI_COALESCE_W_TIMEOUT_EN).
package axi_coalesce_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_FILL,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_AWCACHE    = 4'b0010;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_BURST_LEN  = 16;
    localparam int DEF_S_DATA_W   = 32;
    localparam int DEF_M_DATA_W   = 256;
    localparam int LINE_BYTES     = DEF_BURST_LEN * DEF_M_DATA_W / 8;
    localparam int WORDS_PER_BEAT = DEF_M_DATA_W / DEF_S_DATA_W;

endpackage

// File: rtl/axi_coalesce_linebuf.sv
// One line of byte-enabled storage plus its byte-valid map: narrow merge port,
// wide beat read port, map clear, and an all-ones flag that includes the write in flight.
module axi_coalesce_linebuf
    import axi_coalesce_pkg::*;
#(
    parameter int LINE_B   = LINE_BYTES,
    parameter int S_DATA_W = DEF_S_DATA_W,
    parameter int M_DATA_W = DEF_M_DATA_W
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             clear,
    input  logic                                             wr_en,
    input  logic [clogb2(LINE_B)-clogb2(S_DATA_W/8)-1:0]     wr_word,
    input  logic [S_DATA_W-1:0]                              wr_data,
    input  logic [S_DATA_W/8-1:0]                            wr_strb,
    input  logic [clogb2(LINE_B/(M_DATA_W/8))-1:0]           rd_beat,
    output logic [M_DATA_W-1:0]                              rd_data,
    output logic [M_DATA_W/8-1:0]                            rd_strb,
    output logic                                             full_next
);

    localparam int SB    = S_DATA_W / 8;
    localparam int SB_LG = clogb2(SB);
    localparam int MB_LG = clogb2(M_DATA_W / 8);
    localparam int MD_LG = clogb2(M_DATA_W);

    logic [LINE_B*8-1:0] data_q;
    logic [LINE_B-1:0]   map_q;
    logic [LINE_B-1:0]   wr_mask;
    logic [LINE_B*8-1:0] data_sh;
    logic [LINE_B-1:0]   map_sh;

    always_comb begin
        wr_mask = '0;
        if (wr_en)
            wr_mask = {{(LINE_B-SB){1'b0}}, wr_strb} << {wr_word, {SB_LG{1'b0}}};
    end

    assign full_next = &(map_q | wr_mask);

    // Payload bytes carry no reset; only the map decides what leaves on the bus.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LINE_B; i++)
            if (wr_mask[i]) data_q[i*8 +: 8] <= wr_data[(i % SB)*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) map_q <= '0;
        else                map_q <= map_q | wr_mask;
    end

    assign data_sh = data_q >> {rd_beat, {MD_LG{1'b0}}};
    assign map_sh  = map_q >> {rd_beat, {MB_LG{1'b0}}};
    assign rd_data = data_sh[M_DATA_W-1:0];
    assign rd_strb = map_sh[M_DATA_W/8-1:0];

endmodule

// File: rtl/axi_coalesce_w.sv
// Merges posted single-beat narrow AXI writes into one line and writes it out as a
// full-length wide INCR burst with byte strobes. Optional idle flush: AXI_COALESCE_W_TIMEOUT_EN.
module axi_coalesce_w
    import axi_coalesce_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 48,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 256
`ifdef AXI_COALESCE_W_TIMEOUT_EN
    ,
    parameter int C_IDLE_TIMEOUT     = 256
`endif
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            flush,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic [3:0]                      m_axi_awcache,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic                            busy
);

    localparam int M_BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int S_BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int LINE_B  = C_M_AXI_BURST_LEN * M_BYTES;
    localparam int OFF_W   = clogb2(LINE_B);
    localparam int SB_LG   = clogb2(S_BYTES);
    localparam int BEAT_W  = clogb2(C_M_AXI_BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_AXI_BURST_LEN - 1);

    state_t                          state, state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_base;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   line_base;
    logic                            hit, slave_open, take, miss;
    logic                            full_next, idle_to, buf_clear;
    logic                            bvalid_q;
    logic [BEAT_W-1:0]               beat_q;
    logic                            unused_bits;

    assign line_base  = {s_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign hit        = (line_base == cur_base);
    assign slave_open = (state == ST_EMPTY || state == ST_FILL) && (!bvalid_q || s_axi_bready)
                        && (state == ST_EMPTY || hit);
    assign take       = s_axi_awvalid && s_axi_wvalid && slave_open;
    // A miss is only observed, never consumed; it is retried once the line drains.
    assign miss       = (state == ST_FILL) && s_axi_awvalid && s_axi_wvalid && !hit;
    assign buf_clear  = (state == ST_B) && m_axi_bvalid;

`ifdef AXI_COALESCE_W_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // idle_cnt holds the number of cycles since the last take.
    always_ff @(posedge clk) begin
        if (!rstn)                 idle_cnt <= '0;
        else if (take)             idle_cnt <= 16'd1;
        else if (state == ST_FILL) idle_cnt <= idle_cnt + 16'd1;
        else                       idle_cnt <= '0;
    end

    assign idle_to = (state == ST_FILL) && !take && (idle_cnt + 16'd1 == 16'(C_IDLE_TIMEOUT));
`else
    assign idle_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_EMPTY;
            bvalid_q <= 1'b0;
            beat_q   <= '0;
        end else begin
            state <= state_nxt;
            if (take)              bvalid_q <= 1'b1;
            else if (s_axi_bready) bvalid_q <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take && state == ST_EMPTY) cur_base <= line_base;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (take) state_nxt = full_next ? ST_AW : ST_FILL;
            ST_FILL:  if ((take && full_next) || flush || miss || idle_to) state_nxt = ST_AW;
            ST_AW:    if (m_axi_awready) state_nxt = ST_W;
            ST_W:     if (m_axi_wready && beat_q == LAST_BEAT) state_nxt = ST_B;
            ST_B:     if (m_axi_bvalid) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    axi_coalesce_linebuf #(
        .LINE_B   (LINE_B),
        .S_DATA_W (C_S_AXI_DATA_WIDTH),
        .M_DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_linebuf (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (buf_clear),
        .wr_en     (take),
        .wr_word   (s_axi_awaddr[OFF_W-1:SB_LG]),
        .wr_data   (s_axi_wdata),
        .wr_strb   (s_axi_wstrb),
        .rd_beat   (beat_q),
        .rd_data   (m_axi_wdata),
        .rd_strb   (m_axi_wstrb),
        .full_next (full_next)
    );

    assign s_axi_awready = slave_open;
    assign s_axi_wready  = slave_open;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = AXI_RESP_OKAY;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = cur_base;
    assign m_axi_awlen   = 8'(C_M_AXI_BURST_LEN - 1);
    assign m_axi_awsize  = 3'(clogb2(M_BYTES));
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awcache = AXI_AWCACHE;
    assign m_axi_awvalid = (state == ST_AW);
    assign m_axi_wvalid  = (state == ST_W);
    assign m_axi_wlast   = (state == ST_W) && (beat_q == LAST_BEAT);
    assign m_axi_bready  = 1'b1;
    assign busy          = (state != ST_EMPTY);

    assign unused_bits = ^{m_axi_bresp, s_axi_awaddr[SB_LG-1:0]};

endmodule

// File: tb/tb_axi_coalesce_w.sv
// Scoreboard bench for axi_coalesce_w: a byte-level line model builds the expected
// bursts, which a bus monitor pops and compares as the master side drains them.
module tb_axi_coalesce_w;

    logic         clk = 1'b0;
    logic         rstn, flush;
    logic [47:0]  s_axi_awaddr;
    logic         s_axi_awvalid, s_axi_awready;
    logic [31:0]  s_axi_wdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_wvalid, s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid, s_axi_bready;
    logic [0:0]   m_axi_awid;
    logic [47:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic [3:0]   m_axi_awcache;
    logic         m_axi_awvalid, m_axi_awready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;
    logic         busy;

    always #5 clk = ~clk;

`ifdef AXI_COALESCE_W_TIMEOUT_EN
    axi_coalesce_w #(.C_IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .busy(busy)
    );
`else
    axi_coalesce_w dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .busy(busy)
    );
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mb_cyc = 0;
    int mon_beat = 0;
    int b_exp = 0;
    int b_seen = 0;
    logic wr_toggle = 1'b0;

    logic [7:0]   mdata [512];
    logic         mmap  [512];
    logic [47:0]  exp_aw_q [$];
    logic [255:0] exp_wd_q [$];
    logic [31:0]  exp_ws_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) begin
            mdata[i] = 8'h00;
            mmap[i]  = 1'b0;
        end
    endtask

    task automatic model_write(input logic [47:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int off;
        off = int'(addr[8:0]);
        for (int b = 0; b < 4; b++)
            if (strb[b]) begin
                mdata[off + b] = data[b*8 +: 8];
                mmap[off + b]  = 1'b1;
            end
    endtask

    task automatic push_burst(input logic [47:0] base);
        logic [255:0] d;
        logic [31:0]  s;
        exp_aw_q.push_back(base);
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 32; j++) begin
                d[j*8 +: 8] = mdata[k*32 + j];
                s[j]        = mmap[k*32 + j];
            end
            exp_wd_q.push_back(d);
            exp_ws_q.push_back(s);
        end
        model_clear();
    endtask

    // Called aligned to 1 time unit after a rising edge; returns aligned the same way.
    task automatic try_write(input logic [47:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int budget, output bit ok);
        ok = 1'b0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (s_axi_awready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                model_write(addr, data, strb);
                b_exp++;
            end
            @(posedge clk);
            #1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic write(input logic [47:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        try_write(addr, data, strb, 200, ok);
        check("write_accept", ok, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            if (exp_aw_q.size() == 0 && exp_wd_q.size() == 0 && !busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check(tag, done, 1);
    endtask

    // Master-side monitor: every handshake pops the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw_q.size() == 0) check("aw_unexpected", m_axi_awaddr, 0);
                else begin
                    check("awaddr", m_axi_awaddr, exp_aw_q.pop_front());
                    check("awlen", m_axi_awlen, 15);
                    check("awsize", m_axi_awsize, 5);
                    check("awburst", m_axi_awburst, 1);
                    check("awcache", m_axi_awcache, 2);
                    check("awid", m_axi_awid, 0);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_wd_q.size() == 0) check("w_unexpected", m_axi_wstrb, 0);
                else begin
                    logic [255:0] ed, mask;
                    logic [31:0]  es;
                    ed = exp_wd_q.pop_front();
                    es = exp_ws_q.pop_front();
                    for (int j = 0; j < 32; j++) mask[j*8 +: 8] = {8{es[j]}};
                    check("wstrb", m_axi_wstrb, es);
                    check("wdata", m_axi_wdata & mask, ed);
                    check("wlast", m_axi_wlast, (mon_beat == 15));
                end
                mon_beat = (mon_beat + 1) % 16;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                b_seen++;
                check("s_bresp", s_axi_bresp, 0);
            end
        end
    end

    // Master write-response agent: answers each burst a few cycles after its last beat.
    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        forever begin
            @(negedge clk);
            if (rstn && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
                repeat (3) @(posedge clk);
                #1 m_axi_bvalid = 1'b1;
                mb_cyc = cyc;
                @(posedge clk);
                #1 m_axi_bvalid = 1'b0;
            end
        end
    end

    initial begin
        m_axi_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_axi_wready = wr_toggle ? ~m_axi_wready : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int aw_cyc;
        rstn = 1'b0; flush = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; m_axi_awready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        check("rst_busy", busy, 0);
        check("rst_awready", s_axi_awready, 1);
        check("rst_s_bvalid", s_axi_bvalid, 0);
        check("rst_m_awvalid", m_axi_awvalid, 0);
        check("rst_m_wvalid", m_axi_wvalid, 0);
        check("rst_m_bready", m_axi_bready, 1);

        pulse_flush();
        repeat (3) @(posedge clk);
        #1 check("flush_empty_ignored", busy, 0);

        // Full line of sequential stores.
        for (int i = 0; i < 128; i++) write(48'h1000 + 48'(i*4), $urandom, 4'hF);
        push_burst(48'h1000);
        check("full_aw_latency", m_axi_awvalid, 1);
        wait_drain("drain_full");

        // Partial line closed by a miss; the miss waits for the master response.
        write(48'h1000, 32'h1122_3344, 4'hF);
        write(48'h1004, 32'h5566_7788, 4'hF);
        push_burst(48'h1000);
        try_write(48'h2000, 32'hDEAD_BEEF, 4'hF, 200, ok);
        check("miss_accept", ok, 1);
        check("miss_accept_cycle", acc_cyc, mb_cyc + 1);
        push_burst(48'h2000);
        pulse_flush();
        wait_drain("drain_miss");

        // Two-byte store then explicit flush.
        write(48'h1008, 32'hCAFE_BEEF, 4'h3);
        push_burst(48'h1000);
        pulse_flush();
        wait_drain("drain_flush");

        // Flush in the same cycle as a hit store: store lands in the burst.
        write(48'h7000, 32'hA5A5_0001, 4'hF);
        flush = 1'b1;
        write(48'h7004, 32'h0102_0304, 4'hC);
        flush = 1'b0;
        push_burst(48'h7000);
        wait_drain("drain_flush_hit");

        // Full line with the master throttling every other cycle.
        wr_toggle = 1'b1;
        for (int i = 0; i < 128; i++) write(48'h4000 + 48'(i*4), $urandom, 4'hF);
        push_burst(48'h4000);
        wait_drain("drain_toggle");
        wr_toggle = 1'b0;

        // Slave response back-pressure blocks the next take.
        s_axi_bready = 1'b0;
        write(48'h5000, 32'h0BAD_F00D, 4'hF);
        try_write(48'h5004, 32'h1234_5678, 4'hF, 5, ok);
        check("bready_stall", ok, 0);
        check("bready_awready", s_axi_awready, 0);
        s_axi_bready = 1'b1;
        write(48'h5004, 32'h1234_5678, 4'hF);
        push_burst(48'h5000);
        pulse_flush();
        wait_drain("drain_bready");

`ifdef AXI_COALESCE_W_TIMEOUT_EN
        write(48'h3000, 32'h3333_3333, 4'hF);
        push_burst(48'h3000);
        aw_cyc = acc_cyc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (m_axi_awvalid) begin
                aw_cyc = cyc;
                break;
            end
        end
        check("timeout_latency", aw_cyc - acc_cyc, 8);
        @(posedge clk);
        #1;
        wait_drain("drain_timeout");
`else
        write(48'h6000, 32'h6666_6666, 4'hF);
        repeat (30) @(posedge clk);
        #1 check("partial_stays", m_axi_awvalid, 0);
        check("partial_busy", busy, 1);
`endif

        // Reset abandons a pending line and its byte map.
        write(48'h6008, 32'h7777_7777, 4'hF);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst2_busy", busy, 0);
        check("rst2_s_bvalid", s_axi_bvalid, 0);
        pulse_flush();
        repeat (3) @(posedge clk);
        #1 check("rst2_no_burst", m_axi_awvalid, 0);
        write(48'h6004, 32'h4444_4444, 4'hF);
        push_burst(48'h6000);
        pulse_flush();
        wait_drain("drain_after_reset");

        check("b_count", b_seen, b_exp);
        check("queues_empty", exp_aw_q.size() + exp_wd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
